ram_mfc_param: RTL
==================

// Module: ram_mfc_param
// PURPOSE
//  Parametrised single-port synchronous RAM with programmable wait states and an
//  MFC (memory-function-complete) handshake. Next generation of the CPU's 32x512
//  main memory: sits between the MAR/MDR datapath and storage, so the control unit
//  stalls on MFC instead of assuming a fixed 1-cycle access.
// PARAMETERS
//  DATA_W       32   word width in bits
//  ADDR_W       9    address width; depth = 2**ADDR_W words
//  WAIT_STATES  1    extra idle cycles before access completes (0..15)
// PORTS
//  clk         in   1       system clock, all state on rising edge
//  clr_n       in   1       asynchronous active-low reset
//  Read        in   1       read request (sampled in IDLE only)
//  Write       in   1       write request (sampled in IDLE only)
//  address     in   ADDR_W  word address
//  data_in     in   DATA_W  write data
//  data_out    out  DATA_W  read data; holds last read value
//  MFC         out  1       one-cycle pulse: access complete
//  busy        out  1       high from request accept until MFC cycle (inclusive)
//  req_err     out  1       one-cycle pulse: Read & Write both high in IDLE
//  parity_err  out  1       one-cycle pulse with MFC on read parity mismatch
// BEHAVIOUR
//  - Reset (clr_n=0, async): FSM->IDLE, wait counter=0, data_out=0, MFC=0, busy=0,
//    req_err=0, parity_err=0. Memory array NOT cleared by reset; power-up contents 0.
//  - FSM: IDLE, WAIT, ACCESS.
//    IDLE: Read^Write=1 -> latch address/data_in/op, busy=1; next WAIT if
//      WAIT_STATES>0 else ACCESS. Read&Write=1 -> req_err pulse, stay IDLE, no access.
//      Neither -> stay IDLE.
//    WAIT: counter counts 1..WAIT_STATES; at WAIT_STATES -> ACCESS.
//    ACCESS: write: mem[addr_q]<=data_q; read: data_out<=mem[addr_q]. MFC=1 for this
//      cycle only (registered), busy=1; next IDLE.
//  - Latency: request sampled on edge N -> MFC high during cycle after edge
//    N+1+WAIT_STATES; data_out valid same cycle as MFC.
//  - Back-to-back: new request may be sampled on the edge ending the ACCESS cycle?
//    No - sampled only in IDLE; min request spacing = WAIT_STATES+2 cycles.
//  - Read/Write/address/data_in changes while busy are ignored (latched copies used).
//  - Reset mid-operation aborts: pending write NOT committed, no MFC, data_out=0.
//  - Address wraps naturally modulo 2**ADDR_W; no out-of-range case exists.
//  - WAIT_STATES>15 is a configuration error ($error in elaboration).
// CONFIGURATION
//  MEM_PARITY_EN defined: each word stores one extra even-parity bit (^data) written
//    on every write; on read, recomputed parity != stored -> parity_err pulses in the
//    MFC cycle; data_out still returns the stored word.
//  MEM_PARITY_EN undefined: no parity storage; parity_err tied 0.
// TESTING
//  1 WAIT_STATES=1: Write=1, addr=0x075, data_in=0x0000EADF -> busy 3 cycles, MFC
//    in 3rd cycle; later Read addr=0x075 -> data_out=0x0000EADF with MFC.
//  2 WAIT_STATES=0: Read addr=0x050 after write 0x0000A0ED -> MFC and data_out one
//    cycle after request edge, matching legacy 1-cycle timing.
//  3 Read=Write=1 in IDLE, addr=0x010 -> req_err pulse 1 cycle, busy stays 0, mem
//    [0x010] unchanged (read back 0).
//  4 Write 0x12345678 to 0x1FF, drop clr_n in WAIT -> all outputs 0 immediately,
//    no MFC; read 0x1FF returns prior value (0).
//  5 Toggle address/data_in during WAIT of a write to 0x004 (0xCAFEF00D) -> only
//    0xCAFEF00D at 0x004 is written; 0x005 untouched.
//  6 MEM_PARITY_EN: write 0x00000001 to 0x020, backdoor-flip bit 0 of stored word,
//    read -> data_out=0x00000000, parity_err=1 with MFC; without macro parity_err=0.

Source files
------------

// File: rtl/ram_mfc_param.sv
// Single-port synchronous RAM with WAIT_STATES idle cycles and an MFC pulse that marks access completion.
// Latency: request edge N -> MFC in the cycle after edge N+1+WAIT_STATES. No backpressure: inputs are ignored while busy.
// Optional MEM_PARITY_EN keeps an even-parity bit per word and pulses parity_err on a corrupted read.
module ram_mfc_param #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              MFC,
    output logic              busy,
    output logic              req_err,
    output logic              parity_err
);

    localparam int         DEPTH = 1 << ADDR_W;
    localparam logic [3:0] WS_L  = 4'(WAIT_STATES);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_cfg
        $error("ram_mfc_param: WAIT_STATES must be within 0..15");
    end

`ifdef MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        wcnt;
    logic [3:0]        wcnt_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              rd_q;
    logic              accept;
    logic              req_clash;
    logic              do_access;

    logic [MEM_W-1:0]  mem [DEPTH];
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rd_word;

    assign accept    = (state == ST_IDLE) && (Read ^ Write);
    assign req_clash = (state == ST_IDLE) && Read && Write;
    assign do_access = (state == ST_ACCESS);

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_nxt = ST_WAIT;
                        wcnt_nxt  = 4'd1;
                    end else begin
                        state_nxt = ST_ACCESS;
                        wcnt_nxt  = 4'd0;
                    end
                end
            end
            ST_WAIT: begin
                if (wcnt == WS_L) begin
                    state_nxt = ST_ACCESS;
                    wcnt_nxt  = 4'd0;
                end else begin
                    wcnt_nxt = wcnt + 4'd1;
                end
            end
            ST_ACCESS: begin
                state_nxt = ST_IDLE;
                wcnt_nxt  = 4'd0;
            end
            default: begin
                state_nxt = ST_IDLE;
                wcnt_nxt  = 4'd0;
            end
        endcase
    end

    // busy stays up through the MFC cycle, which the FSM already spends in IDLE
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= ST_IDLE;
            wcnt     <= 4'd0;
            addr_q   <= '0;
            data_q   <= '0;
            rd_q     <= 1'b0;
            data_out <= '0;
            MFC      <= 1'b0;
            busy     <= 1'b0;
            req_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (accept) begin
                addr_q <= address;
                data_q <= data_in;
                rd_q   <= Read;
            end
            if (do_access && rd_q) begin
                data_out <= rd_word[DATA_W-1:0];
            end
            MFC     <= do_access;
            busy    <= accept || (state != ST_IDLE);
            req_err <= req_clash;
        end
    end

`ifdef MEM_PARITY_EN
    assign wr_word = {^data_q, data_q};
`else
    assign wr_word = data_q;
`endif

    // Storage has no reset: an aborted access never reaches ACCESS, so nothing is committed
    always_ff @(posedge clk) begin
        if (do_access && !rd_q) begin
            mem[addr_q] <= wr_word;
        end
    end

    assign rd_word = mem[addr_q];

`ifdef MEM_PARITY_EN
    logic perr_hit;
    assign perr_hit = (^rd_word[DATA_W-1:0]) != rd_word[DATA_W];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= do_access && rd_q && perr_hit;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
